// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and iteration counter sizing.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FIXUP = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned shift-add multiply / restoring shift-subtract divide datapath.
// One iteration per 'step'; operands arrive as magnitudes on 'load'.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output logic             mul_last
);

  // Multiply: acc accumulates opa (multiplicand shifted left) while opb shifts
  // right, so acc is always in final product position. Divide: acc = {rem, quo}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH:0]     diff;

  always_comb begin
    r_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = r_sh - {1'b0, opa[WIDTH-1:0]};
  end

  always_ff @(posedge clk) begin
    if (load) begin
      acc <= is_div ? {{WIDTH{1'b0}}, a} : '0;
      opa <= {{WIDTH{1'b0}}, (is_div ? b : a)};
      opb <= b;
    end else if (step) begin
      if (is_div) begin
        if (!diff[WIDTH]) acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else              acc <= {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        if (opb[0]) acc <= acc + opa;
        opa <= opa << 1;
        opb <= opb >> 1;
      end
    end
  end

  assign hi_res   = acc[2*WIDTH-1:WIDTH];
  assign lo_res   = acc[WIDTH-1:0];
  assign mul_last = ~|opb[WIDTH-1:1];

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS HI/LO multiply/divide controller with stall generation.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the multiplier is exhausted.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hilo_rd,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic signed [WIDTH-1:0] neg1(input logic signed [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic signed [2*WIDTH-1:0] neg2(input logic signed [2*WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  state_e                    state;
  logic [CW-1:0]             cnt;
  logic                      div_q, neg_q, neg_r, dz_q;
  logic [WIDTH-1:0]          rs_q;
  logic                      load, step, core_div, mul_last, run_done, sgn;
  logic [WIDTH-1:0]          hi_res, lo_res;
  logic signed [2*WIDTH-1:0] prod_fix;
  logic signed [WIDTH-1:0]   q_fix, r_fix;

  assign sgn      = ~op[0];
  assign load     = (state == IDLE) && start;
  assign step     = (state == RUN);
  assign core_div = (state == IDLE) ? op[1] : div_q;
  assign run_done = (cnt == CW'(WIDTH-1)) || (EARLY_OUT && !div_q && mul_last);
  assign stall    = busy & (start | hilo_rd | hi_we | lo_we);

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .load     (load),
    .step     (step),
    .is_div   (core_div),
    .a        (mag(rs_data, sgn)),
    .b        (mag(rt_data, sgn)),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .mul_last (mul_last)
  );

  always_comb begin
    prod_fix = neg2({hi_res, lo_res}, neg_q);
    q_fix    = neg1(lo_res, neg_q);
    r_fix    = neg1(hi_res, neg_r);
  end

  // Raw dividend kept for the divide-by-zero HI result.
  always_ff @(posedge clk) begin
    if (load) rs_q <= rs_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_q       <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            div_q       <= op[1];
            neg_q       <= sgn & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r       <= sgn & rs_data[WIDTH-1];
            dz_q        <= op[1] && (rt_data == '0);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (run_done) state <= FIXUP;
        end
        FIXUP: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (div_q) begin
            if (dz_q) begin
              lo          <= '1;
              hi          <= rs_q;
              div_by_zero <= 1'b1;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; honours MULDIV_EARLY_OUT_EN for latency expectations.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, hilo_rd, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, stall, div_by_zero;

  int tests = 0;
  int fails = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hilo_rd(hilo_rd),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in the current cycle (cycle 0) and follows it until two
  // cycles past the done pulse, or a 60-cycle bound.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int dcyc, output int bcnt, output int dcnt);
    dcyc = -1; bcnt = 0; dcnt = 0;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (dcyc < 0) dcyc = c;
      end
      if (dcyc >= 0 && c >= dcyc + 2) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mthi_mtlo();
    hi_we = 1'b1; wdata = 32'hA5A5_0001; hilo_rd = 1'b1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL idle_stall: got %b want 0", stall); end
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A_0002;
    tests++; if (hi !== 32'hA5A5_0001) begin fails++; $display("FAIL mthi: got %h want a5a50001", hi); end
    tick();
    lo_we = 1'b0; hilo_rd = 1'b0;
    tests++; if (lo !== 32'h5A5A_0002) begin fails++; $display("FAIL mtlo: got %h want 5a5a0002", lo); end
  endtask

  task automatic test_mult();
    int d, b, n, exp_d;
    exp_d = EO ? 5 : 34;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, d, b, n);
    tests++; if (d != exp_d) begin fails++; $display("FAIL mult_done_cycle: got %0d want %0d", d, exp_d); end
    tests++; if (b != exp_d - 1) begin fails++; $display("FAIL mult_busy_cycles: got %0d want %0d", b, exp_d - 1); end
    tests++; if (n != 1) begin fails++; $display("FAIL mult_done_width: got %0d want 1", n); end
    tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    tests++; if (lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, b, n);
    tests++; if (d != 34) begin fails++; $display("FAIL multu_max_done_cycle: got %0d want 34", d); end
    tests++; if (hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_max_hi: got %h want fffffffe", hi); end
    tests++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_max_lo: got %h want 00000001", lo); end
  endtask

  task automatic test_div();
    int d, b, n;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, d, b, n);
    tests++; if (d != 34) begin fails++; $display("FAIL div_done_cycle: got %0d want 34", d); end
    tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    run_op(2'b11, 32'd7, 32'd2, d, b, n);
    tests++; if (lo !== 32'd3) begin fails++; $display("FAIL divu_lo: got %h want 00000003", lo); end
    tests++; if (hi !== 32'd1) begin fails++; $display("FAIL divu_hi: got %h want 00000001", hi); end
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, d, b, n);
    tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_negdivisor_lo: got %h want fffffffd", lo); end
    tests++; if (hi !== 32'd1) begin fails++; $display("FAIL div_negdivisor_hi: got %h want 00000001", hi); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, d, b, n);
    tests++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL div_intmin_lo: got %h want 80000000", lo); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL div_intmin_hi: got %h want 00000000", hi); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL div_intmin_dbz: got %b want 0", div_by_zero); end
  endtask

  task automatic test_div_zero();
    int d, b, n, c;
    run_op(2'b11, 32'h0000_1234, 32'd0, d, b, n);
    tests++; if (d != 34) begin fails++; $display("FAIL dz_done_cycle: got %0d want 34", d); end
    tests++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL dz_lo: got %h want ffffffff", lo); end
    tests++; if (hi !== 32'h0000_1234) begin fails++; $display("FAIL dz_hi: got %h want 00001234", hi); end
    tests++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, d, b, n);
    tests++; if (hi !== 32'hFFFF_FFFB) begin fails++; $display("FAIL dz_signed_hi: got %h want fffffffb", hi); end
    tests++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dz_signed_flag: got %b want 1", div_by_zero); end
    op = 2'b01; rs_data = 32'd2; rt_data = 32'h8000_0000; start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL dz_clear_on_start: got %b want 0", div_by_zero); end
    c = 0;
    while (done !== 1'b1 && c < 60) begin tick(); c++; end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL dz_followup_timeout: done=%b after %0d cycles", done, c); end
    tests++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin fails++; $display("FAIL dz_followup_result: got %h%h want 0000000100000000", hi, lo); end
    tick(); tick();
  endtask

  task automatic test_stall();
    logic exp;
    op = 2'b01; rs_data = 32'd3; rt_data = 32'h8000_0001; start = 1'b1;
    tick();
    for (int c = 1; c <= 34; c++) begin
      start = (c == 5);
      if (c == 5) begin op = 2'b11; rs_data = 32'd99; rt_data = 32'd0; end
      hilo_rd = (c >= 10);
      #1;
      exp = (c == 5) || (c >= 10 && c <= 33);
      tests++; if (stall !== exp) begin fails++; $display("FAIL stall_c%0d: got %b want %b", c, stall, exp); end
      if (c == 34) begin
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL stall_done_c34: got %b want 1", done); end
      end
      tick();
    end
    hilo_rd = 1'b0;
    tests++; if (hi !== 32'd1) begin fails++; $display("FAIL stall_multu_hi: got %h want 00000001", hi); end
    tests++; if (lo !== 32'h8000_0003) begin fails++; $display("FAIL stall_multu_lo: got %h want 80000003", lo); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL stall_ignored_start_dbz: got %b want 0", div_by_zero); end
    tick();
  endtask

  task automatic test_mtlo_with_start();
    int c;
    lo_we = 1'b1; wdata = 32'h77;
    tick();
    op = 2'b01; rs_data = 32'd6; rt_data = 32'd7; start = 1'b1; lo_we = 1'b1; hi_we = 1'b1; wdata = 32'd5;
    tick();
    start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    tests++; if (lo !== 32'h77) begin fails++; $display("FAIL start_wins_lo_c1: got %h want 00000077", lo); end
    tests++; if (hi !== 32'd1) begin fails++; $display("FAIL start_wins_hi_c1: got %h want 00000001", hi); end
    c = 0;
    while (done !== 1'b1 && c < 60) begin tick(); c++; end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL start_wins_timeout: done=%b after %0d cycles", done, c); end
    tests++; if (lo !== 32'd42) begin fails++; $display("FAIL start_wins_lo: got %h want 0000002a", lo); end
    tests++; if (hi !== 32'd0) begin fails++; $display("FAIL start_wins_hi: got %h want 00000000", hi); end
    tick();
  endtask

  task automatic test_reset_mid();
    int d, b, n, pulses;
    op = 2'b10; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy); end
    tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL midreset_hilo: got %h%h want 0", hi, lo); end
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) pulses++;
      tick();
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL midreset_no_done: got %0d pulses want 0", pulses); end
    tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL midreset_hilo_hold: got %h%h want 0", hi, lo); end
    run_op(2'b11, 32'd100, 32'd7, d, b, n);
    tests++; if (d != 34) begin fails++; $display("FAIL midreset_restart_cycle: got %0d want 34", d); end
    tests++; if (lo !== 32'd14) begin fails++; $display("FAIL midreset_restart_lo: got %h want 0000000e", lo); end
    tests++; if (hi !== 32'd2) begin fails++; $display("FAIL midreset_restart_hi: got %h want 00000002", hi); end
  endtask

  task automatic test_early_out();
    int d, b, n, exp_d;
    exp_d = EO ? 3 : 34;
    run_op(2'b01, 32'd9, 32'd1, d, b, n);
    tests++; if (d != exp_d) begin fails++; $display("FAIL eo_rt1_cycle: got %0d want %0d", d, exp_d); end
    tests++; if (lo !== 32'd9) begin fails++; $display("FAIL eo_rt1_lo: got %h want 00000009", lo); end
    tests++; if (hi !== 32'd0) begin fails++; $display("FAIL eo_rt1_hi: got %h want 00000000", hi); end
    run_op(2'b01, 32'd9, 32'd0, d, b, n);
    tests++; if (d != exp_d) begin fails++; $display("FAIL eo_rt0_cycle: got %0d want %0d", d, exp_d); end
    tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL eo_rt0_result: got %h%h want 0", hi, lo); end
    run_op(2'b11, 32'd9, 32'd1, d, b, n);
    tests++; if (d != 34) begin fails++; $display("FAIL eo_div_cycle: got %0d want 34", d); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hilo_rd = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div_zero();
    test_stall();
    test_mtlo_with_start();
    test_reset_mid();
    test_early_out();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
